// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer depth default and Gray conversions.
// Used by both the read_empty and write_full pointer blocks.
package fifo_pkg;

  localparam int FIFO_DEPTH_BIT_DEF = 4;
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(
    input logic [PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(
    input logic [PTR_MAX_W-1:0] g
  );
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Both stages clear to zero on reset.
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/read_empty.sv
// Read-side pointer logic of an async FIFO: read pointer,
// Gray export, empty / almost-empty flags and fill level.
module read_empty
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH_BIT  = FIFO_DEPTH_BIT_DEF,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                      r_clk,
  input  logic                      r_rst,
  input  logic                      r_en,
  input  logic [FIFO_DEPTH_BIT:0]   write_addr_gray,
  output logic                      flag_empty,
  output logic                      flag_almost_empty,
  output logic [FIFO_DEPTH_BIT-1:0] read_addr,
  output logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
  output logic [FIFO_DEPTH_BIT:0]   r_level
);

  localparam int PW = FIFO_DEPTH_BIT + 1;

  logic [PW-1:0] wgray_s2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_q;
  logic [PW-1:0] rbin_d;
  logic [PW-1:0] rgray_q;
  logic [PW-1:0] rgray_d;
  logic [PW-1:0] level_q;
  logic [PW-1:0] level_d;
  logic          empty_q;
  logic          empty_d;
  logic          aempty_q;
  logic          aempty_d;
  logic          accept;

  sync_2ff #(
    .W (PW)
  ) u_wsync (
    .clk   (r_clk),
    .rst_n (r_rst),
    .d     (write_addr_gray),
    .q     (wgray_s2)
  );

  // Flags look at the post-read pointer so the draining read
  // raises empty on the same edge it moves the Gray pointer.
  always_comb begin
    accept   = r_en & ~empty_q;
    rbin_d   = rbin_q + PW'(accept);
    rgray_d  = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
    wbin     = PW'(gray2bin(PTR_MAX_W'(wgray_s2)));
    level_d  = wbin - rbin_d;
    empty_d  = (rgray_d == wgray_s2);
    aempty_d = (int'(level_d) <= ALMOST_EMPTY_TH);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  assign flag_empty        = empty_q;
  assign flag_almost_empty = aempty_q;
  assign read_addr         = rbin_q[FIFO_DEPTH_BIT-1:0];
  assign read_addr_gray    = rgray_q;
  assign r_level           = level_q;

endmodule

// File: tb/tb_read_empty.sv
// Scoreboard bench for read_empty: occupancy model with a two-edge
// write-pointer delay, directed scenarios plus random traffic.
module tb_read_empty;

  localparam int TH = 2;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b0;
  logic       r_en  = 1'b0;
  logic [4:0] write_addr_gray = '0;
  logic       flag_empty;
  logic       flag_almost_empty;
  logic [3:0] read_addr;
  logic [4:0] read_addr_gray;
  logic [4:0] r_level;

  read_empty #(
    .FIFO_DEPTH_BIT  (4),
    .ALMOST_EMPTY_TH (TH)
  ) dut (
    .r_clk             (r_clk),
    .r_rst             (r_rst),
    .r_en              (r_en),
    .write_addr_gray   (write_addr_gray),
    .flag_empty        (flag_empty),
    .flag_almost_empty (flag_almost_empty),
    .read_addr         (read_addr),
    .read_addr_gray    (read_addr_gray),
    .r_level           (r_level)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    int e;
    int a;
    int addr;
    int gray;
    int lvl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_rptr;
  int h1;
  int h2;
  bit m_empty;
  int wp;

  function automatic int g(int x);
    return ((x >> 1) ^ x) & 31;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rptr  = 0;
    h1      = 0;
    h2      = 0;
    m_empty = 1'b1;
    wp      = 0;
  endtask

  task automatic cycle(bit ren, int w);
    int used;
    int acc;
    int lvl;
    exp_t x;
    @(negedge r_clk);
    r_en = ren;
    write_addr_gray = 5'(g(w));
    @(posedge r_clk);
    used = h2;
    h2 = h1;
    h1 = w;
    acc = (ren && !m_empty) ? 1 : 0;
    m_rptr = (m_rptr + acc) % 32;
    lvl = (used - m_rptr + 32) % 32;
    m_empty = (lvl == 0);
    x.e = m_empty ? 1 : 0;
    x.a = (lvl <= TH) ? 1 : 0;
    x.addr = m_rptr % 16;
    x.gray = g(m_rptr);
    x.lvl = lvl;
    q.push_back(x);
  endtask

  task automatic check_reset(string nm);
    chk({nm, "_empty"}, int'(flag_empty), 1);
    chk({nm, "_aempty"}, int'(flag_almost_empty), 1);
    chk({nm, "_addr"}, int'(read_addr), 0);
    chk({nm, "_gray"}, int'(read_addr_gray), 0);
    chk({nm, "_level"}, int'(r_level), 0);
  endtask

  task automatic do_reset(string nm);
    @(negedge r_clk);
    r_en = 1'b1;
    #2;
    r_rst = 1'b0;
    #1;
    check_reset({nm, "_now"});
    @(posedge r_clk);
    @(posedge r_clk);
    #1;
    check_reset({nm, "_held"});
    @(negedge r_clk);
    write_addr_gray = '0;
    r_en = 1'b0;
    r_rst = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge r_clk);
      #2;
      while (q.size() > 0) begin
        x = q.pop_front();
        chk("mon_empty", int'(flag_empty), x.e);
        chk("mon_aempty", int'(flag_almost_empty), x.a);
        chk("mon_addr", int'(read_addr), x.addr);
        chk("mon_gray", int'(read_addr_gray), x.gray);
        chk("mon_level", int'(r_level), x.lvl);
      end
    end
  end

  initial begin : driver
    bit ren;
    model_reset();
    r_rst = 1'b0;
    r_en  = 1'b1;
    #12;
    check_reset("rst_init");
    @(negedge r_clk);
    r_rst = 1'b1;
    r_en  = 1'b0;

    repeat (4) cycle(1'b0, 1);
    #1;
    chk("one_empty", int'(flag_empty), 0);
    chk("one_level", int'(r_level), 1);
    chk("one_aempty", int'(flag_almost_empty), 1);

    do_reset("rst_a");
    repeat (3) cycle(1'b0, 16);
    repeat (20) cycle(1'b1, 16);
    #1;
    chk("drain_gray", int'(read_addr_gray), 24);
    chk("drain_addr", int'(read_addr), 0);
    chk("drain_empty", int'(flag_empty), 1);

    repeat (3) cycle(1'b0, 30);
    repeat (16) cycle(1'b1, 30);
    #1;
    chk("pre_wrap_gray", int'(read_addr_gray), 17);
    repeat (3) cycle(1'b0, 1);
    repeat (4) cycle(1'b1, 1);
    #1;
    chk("wrap_gray", int'(read_addr_gray), 1);
    chk("wrap_empty", int'(flag_empty), 1);

    do_reset("rst_b");
    repeat (3) cycle(1'b0, 5);
    repeat (2) cycle(1'b1, 5);
    #1;
    chk("ae_lvl3_aempty", int'(flag_almost_empty), 0);
    cycle(1'b1, 5);
    #1;
    chk("ae_lvl2_level", int'(r_level), 2);
    chk("ae_lvl2_aempty", int'(flag_almost_empty), 1);
    repeat (3) cycle(1'b1, 5);

    do_reset("rst_c");
    repeat (3) cycle(1'b0, 9);
    repeat (2) cycle(1'b1, 9);
    #1;
    chk("mid_level7", int'(r_level), 7);
    do_reset("rst_mid");

    repeat (400) begin
      ren = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 &&
          ((wp - m_rptr + 32) % 32) < 16) begin
        wp = (wp + 1) % 32;
      end
      cycle(ren, wp);
    end

    @(posedge r_clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
